// File: rtl/div_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO divide sequencer.
// Holds the default operand width and the sequencer state encodings.
// No logic lives here; imported by div_hilo_ctrl and abs_neg.
package div_hilo_ctrl_pkg;

    localparam int NBIT_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/abs_neg.sv
// Conditional two's-complement negate: Y = Neg ? -A : A.
// Purely combinational, zero latency; no handshake.
// Ports: A (value), Neg (negate select), Y (result). Used for operand
// magnitudes and for quotient/remainder sign fix-up.
module abs_neg
    import div_hilo_ctrl_pkg::*;
#(
    parameter int NBit = NBIT_DEF
) (
    input  logic [NBit-1:0] A,
    input  logic            Neg,
    output logic [NBit-1:0] Y
);

    // Wraps in NBit bits: the most negative value negates to itself.
    assign Y = Neg ? (~A + {{(NBit-1){1'b0}}, 1'b1}) : A;

endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequencer in front of the restoring Divider; owns architectural HI/LO.
// Latency: Start + LOAD + RUN (until DivDone) + FIX; Busy covers LOAD..FIX.
// Backpressure: Start and MTHI/MTLO writes are ignored while Busy.
// Ports: Clk/Reset (sync, active-high); Start/Signed/OpA/OpB issue a DIV(U);
// HiWe/LoWe/WData are MTHI/MTLO; Busy/Hi/Lo to the pipeline; Div* to/from
// the Divider. Build option DIV_ZERO_KEEP_EN: a zero divisor leaves HI/LO
// untouched and never raises Busy.
module div_hilo_ctrl
    import div_hilo_ctrl_pkg::*;
#(
    parameter int NBit = NBIT_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Signed,
    input  logic [NBit-1:0] OpA,
    input  logic [NBit-1:0] OpB,
    input  logic            HiWe,
    input  logic            LoWe,
    input  logic [NBit-1:0] WData,
    output logic            Busy,
    output logic [NBit-1:0] Hi,
    output logic [NBit-1:0] Lo,
    output logic            DivWork,
    output logic [NBit-1:0] DivDividend,
    output logic [NBit-1:0] DivDivisor,
    input  logic [NBit-1:0] DivQuot,
    input  logic [NBit-1:0] DivRem,
    input  logic            DivDone
);

    state_t          state;
    logic            qneg;
    logic            rneg;
    logic            launch;
    logic            a_neg;
    logic            b_neg;
    logic [NBit-1:0] a_mag;
    logic [NBit-1:0] b_mag;
    logic [NBit-1:0] lo_fix;
    logic [NBit-1:0] hi_fix;

    assign a_neg = Signed & OpA[NBit-1];
    assign b_neg = Signed & OpB[NBit-1];

`ifdef DIV_ZERO_KEEP_EN
    // A zero divisor is swallowed in IDLE so HI/LO keep their old contents.
    assign launch = Start & (OpB != '0);
`else
    assign launch = Start;
`endif

    abs_neg #(.NBit(NBit)) u_abs_a   (.A(OpA),     .Neg(a_neg), .Y(a_mag));
    abs_neg #(.NBit(NBit)) u_abs_b   (.A(OpB),     .Neg(b_neg), .Y(b_mag));
    abs_neg #(.NBit(NBit)) u_fix_quo (.A(DivQuot), .Neg(qneg),  .Y(lo_fix));
    abs_neg #(.NBit(NBit)) u_fix_rem (.A(DivRem),  .Neg(rneg),  .Y(hi_fix));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_IDLE;
            Busy        <= 1'b0;
            Hi          <= '0;
            Lo          <= '0;
            DivWork     <= 1'b0;
            DivDividend <= '0;
            DivDivisor  <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // MT writes land even alongside Start; FIX overwrites later.
                    if (HiWe) Hi <= WData;
                    if (LoWe) Lo <= WData;
                    if (launch) begin
                        DivDividend <= a_mag;
                        DivDivisor  <= b_mag;
                        qneg        <= a_neg ^ b_neg;
                        rneg        <= a_neg;
                        Busy        <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Work stayed low through LOAD so the Divider reloads.
                    DivWork <= 1'b1;
                    state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (DivDone) begin
                        DivWork <= 1'b0;
                        state   <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    Lo    <= lo_fix;
                    Hi    <= hi_fix;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
module tb_div_hilo_ctrl;

    localparam int NB = 32;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Signed;
    logic [NB-1:0] OpA;
    logic [NB-1:0] OpB;
    logic          HiWe;
    logic          LoWe;
    logic [NB-1:0] WData;
    logic          Busy;
    logic [NB-1:0] Hi;
    logic [NB-1:0] Lo;
    logic          DivWork;
    logic [NB-1:0] DivDividend;
    logic [NB-1:0] DivDivisor;
    logic [NB-1:0] DivQuot;
    logic [NB-1:0] DivRem;
    logic          DivDone;

    int checks = 0;
    int passed = 0;
    logic [NB-1:0] exp_hi;

    div_hilo_ctrl #(.NBit(NB)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Signed(Signed),
        .OpA(OpA), .OpB(OpB), .HiWe(HiWe), .LoWe(LoWe), .WData(WData),
        .Busy(Busy), .Hi(Hi), .Lo(Lo), .DivWork(DivWork),
        .DivDividend(DivDividend), .DivDivisor(DivDivisor),
        .DivQuot(DivQuot), .DivRem(DivRem), .DivDone(DivDone)
    );

    always #5 Clk = ~Clk;

    // Behavioural stand-in for the restoring Divider: reloads while Work=0,
    // raises Done after NB Work cycles; divide-by-zero yields a zero result.
    int div_cnt;
    always @(posedge Clk) begin
        if (!DivWork) begin
            div_cnt <= 0;
            DivDone <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1;
            if (div_cnt + 1 == NB) DivDone <= 1'b1;
        end
    end
    assign DivQuot = (DivDivisor == '0) ? '0 : DivDividend / DivDivisor;
    assign DivRem  = (DivDivisor == '0) ? '0 : DivDividend % DivDivisor;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Issue one division and count the cycles Busy stays high.
    task automatic do_div(input logic sgn, input logic [NB-1:0] a,
                          input logic [NB-1:0] b, output int bc,
                          output logic [NB-1:0] dd, output logic [NB-1:0] dv);
        Start = 1'b1; Signed = sgn; OpA = a; OpB = b;
        tick();
        Start = 1'b0;
        dd = DivDividend;
        dv = DivDivisor;
        bc = 0;
        while (Busy && bc < 200) begin
            bc++;
            tick();
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; OpA = '0; OpB = '0;
        HiWe = 1'b0; LoWe = 1'b0; WData = '0;
        tick(); tick();
        Reset = 1'b0;
        checks++;
        if ({Busy, DivWork, Hi, Lo, DivDividend, DivDivisor} !== '0)
            $display("FAIL reset_state: busy=%b work=%b hi=%h lo=%h dd=%h dv=%h required all 0",
                     Busy, DivWork, Hi, Lo, DivDividend, DivDivisor);
        else passed++;
    endtask

    task automatic test_divu;
        int bc;
        logic [NB-1:0] dd, dv;
        // Work must be low in LOAD and high in RUN.
        Start = 1'b1; Signed = 1'b0; OpA = 32'd100; OpB = 32'd7;
        tick();
        Start = 1'b0;
        checks++;
        if (DivWork !== 1'b0 || Busy !== 1'b1)
            $display("FAIL load_work: work=%b busy=%b required 0/1", DivWork, Busy);
        else passed++;
        tick();
        checks++;
        if (DivWork !== 1'b1) $display("FAIL run_work: work=%b required 1", DivWork);
        else passed++;
        while (Busy) tick();
        do_div(1'b0, 32'd100, 32'd7, bc, dd, dv);
        checks++;
        if (bc !== NB + 3) $display("FAIL divu_busy_len: got %0d required %0d", bc, NB + 3);
        else passed++;
        checks++;
        if (Lo !== 32'd14 || Hi !== 32'd2)
            $display("FAIL divu_100_7: lo=%h hi=%h required 0000000e/00000002", Lo, Hi);
        else passed++;
    endtask

    task automatic test_signed;
        int bc;
        logic [NB-1:0] dd, dv;
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, bc, dd, dv);
        checks++;
        if (dd !== 32'd100 || dv !== 32'd7)
            $display("FAIL div_neg_mag: dd=%h dv=%h required 00000064/00000007", dd, dv);
        else passed++;
        checks++;
        if (Lo !== 32'hFFFFFFF2 || Hi !== 32'hFFFFFFFE)
            $display("FAIL div_m100_7: lo=%h hi=%h required fffffff2/fffffffe", Lo, Hi);
        else passed++;
        do_div(1'b1, 32'd100, 32'hFFFFFFF9, bc, dd, dv);
        checks++;
        if (Lo !== 32'hFFFFFFF2 || Hi !== 32'd2)
            $display("FAIL div_100_m7: lo=%h hi=%h required fffffff2/00000002", Lo, Hi);
        else passed++;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, bc, dd, dv);
        checks++;
        if (Lo !== 32'h80000000 || Hi !== 32'd0)
            $display("FAIL div_min_m1: lo=%h hi=%h required 80000000/00000000", Lo, Hi);
        else passed++;
    endtask

    task automatic test_div_zero;
        int bc;
        logic [NB-1:0] dd, dv;
        HiWe = 1'b1; WData = 32'hAA;
        tick();
        HiWe = 1'b0; LoWe = 1'b1; WData = 32'h55;
        tick();
        LoWe = 1'b0;
        checks++;
        if (Hi !== 32'hAA || Lo !== 32'h55)
            $display("FAIL mt_write: hi=%h lo=%h required 000000aa/00000055", Hi, Lo);
        else passed++;
        do_div(1'b0, 32'd5, 32'd0, bc, dd, dv);
`ifdef DIV_ZERO_KEEP_EN
        exp_hi = 32'hAA;
        checks++;
        if (bc !== 0) $display("FAIL dz_busy: busy cycles %0d required 0", bc);
        else passed++;
        checks++;
        if (Hi !== 32'hAA || Lo !== 32'h55)
            $display("FAIL dz_keep: hi=%h lo=%h required 000000aa/00000055", Hi, Lo);
        else passed++;
`else
        exp_hi = 32'd0;
        checks++;
        if (bc !== NB + 3) $display("FAIL dz_busy: busy cycles %0d required %0d", bc, NB + 3);
        else passed++;
        checks++;
        if (Hi !== 32'd0 || Lo !== 32'd0)
            $display("FAIL dz_zero: hi=%h lo=%h required 00000000/00000000", Hi, Lo);
        else passed++;
`endif
    endtask

    task automatic test_busy_ignore;
        int bc;
        Start = 1'b1; Signed = 1'b0; OpA = 32'd1000; OpB = 32'd10;
        tick();
        Start = 1'b0;
        bc = 0;
        while (Busy && bc < 200) begin
            bc++;
            if (bc == 6) begin
                Start = 1'b1; OpA = 32'd7; OpB = 32'd2;
                HiWe = 1'b1; WData = 32'h1234;
            end else begin
                Start = 1'b0; HiWe = 1'b0;
            end
            if (bc == 8) begin
                checks++;
                if (Hi !== exp_hi || DivDividend !== 32'd1000)
                    $display("FAIL busy_mt_ignored: hi=%h dd=%h required %h/000003e8",
                             Hi, DivDividend, exp_hi);
                else passed++;
            end
            tick();
        end
        Start = 1'b0; HiWe = 1'b0;
        checks++;
        if (bc !== NB + 3) $display("FAIL busy_len_ignore: got %0d required %0d", bc, NB + 3);
        else passed++;
        checks++;
        if (Lo !== 32'd100 || Hi !== 32'd0)
            $display("FAIL busy_result: lo=%h hi=%h required 00000064/00000000", Lo, Hi);
        else passed++;
    endtask

    task automatic test_reset_mid_run;
        int bc;
        logic [NB-1:0] dd, dv;
        Start = 1'b1; Signed = 1'b0; OpA = 32'd50; OpB = 32'd4;
        tick();
        Start = 1'b0;
        // After the Start edge: LOAD, then 9 more edges lands in RUN cycle 10.
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (Busy !== 1'b1 || DivWork !== 1'b1)
            $display("FAIL run_before_reset: busy=%b work=%b required 1/1", Busy, DivWork);
        else passed++;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Hi !== '0 || Lo !== '0 || DivWork !== 1'b0 || DivDividend !== '0)
            $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h work=%b dd=%h required 0",
                     Busy, Hi, Lo, DivWork, DivDividend);
        else passed++;
        do_div(1'b0, 32'd9, 32'd3, bc, dd, dv);
        checks++;
        if (Lo !== 32'd3 || Hi !== 32'd0 || bc !== NB + 3)
            $display("FAIL divu_9_3: lo=%h hi=%h busy=%0d required 00000003/00000000/%0d",
                     Lo, Hi, bc, NB + 3);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1);
    end

endmodule
